// File: rtl/buzzer_pkg.sv
`default_nettype none
// ============================================================================
// buzzer_pkg : state encodings and owner codes for the buzzer round host
// Revision   : 1.0
// ============================================================================
package buzzer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      ANSWER = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_P1   = 2'b01;
   localparam logic [1:0] OWN_P2   = 2'b10;
   localparam logic [1:0] OWN_TIE  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// cycle_timer : loadable down-counter that stops at zero
// Revision    : 1.0
// ============================================================================
module cycle_timer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic [WIDTH-1:0] o_value,
   output logic             o_zero
);

   logic [WIDTH-1:0] r_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_value <= '0;
      end else if (i_load) begin
         r_value <= i_load_val;
      end else if (i_dec && (r_value != '0)) begin
         r_value <= r_value - 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_zero  = (r_value == '0);

endmodule
`default_nettype wire

// File: rtl/buzzer_round_host.sv
`default_nettype none
// ============================================================================
// buzzer_round_host : runs buzz and answer windows, applies verdicts, keeps scores
// Revision          : 1.0
// ============================================================================
module buzzer_round_host
   import buzzer_pkg::*;
#(
   parameter int ARM_CYCLES    = 64,
   parameter int ANSWER_CYCLES = 16,
   parameter int SCORE_W       = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_round,
   input  logic               clear_scores,
   input  logic               led1,
   input  logic               led2,
   input  logic               judge_correct,
   input  logic               judge_wrong,
   output logic               control,
   output logic [1:0]         owner,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               round_done,
   output logic               timed_out
);

   localparam int c_tmr_max = (ARM_CYCLES > ANSWER_CYCLES) ? ARM_CYCLES : ANSWER_CYCLES;
   localparam int c_tmr_w   = $clog2(c_tmr_max);
   localparam logic [c_tmr_w-1:0] c_arm_load = c_tmr_w'(ARM_CYCLES - 1);
   localparam logic [c_tmr_w-1:0] c_ans_load = c_tmr_w'(ANSWER_CYCLES - 1);
   localparam logic [SCORE_W-1:0] c_score_max = {SCORE_W{1'b1}};

   state_t               r_state;
   state_t               w_next;
   logic                 w_load;
   logic [c_tmr_w-1:0]   w_load_val;
   logic                 w_dec;
   logic [c_tmr_w-1:0]   w_tmr_value;
   logic                 w_tmr_zero;
   logic                 w_timeout_evt;
   logic                 w_score_inc;
   logic                 w_start_ok;

   logic                 r_control;
   logic [1:0]           r_owner;
   logic [SCORE_W-1:0]   r_score1;
   logic [SCORE_W-1:0]   r_score2;
   logic                 r_round_done;
   logic                 r_timed_out;

   cycle_timer #(.WIDTH(c_tmr_w)) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .i_dec      (w_dec),
      .o_value    (w_tmr_value),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next        = r_state;
      w_load        = 1'b0;
      w_load_val    = c_arm_load;
      w_dec         = 1'b0;
      w_timeout_evt = 1'b0;
      w_score_inc   = 1'b0;
      w_start_ok    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start_round) begin
               w_start_ok = 1'b1;
               w_next     = ARMED;
               w_load     = 1'b1;
            end
         end
         ARMED: begin
            if (led1 && led2) begin
               w_next = DONE;
            end else if (led1 || led2) begin
               w_next     = ANSWER;
               w_load     = 1'b1;
               w_load_val = c_ans_load;
            end else if (w_tmr_zero) begin
               w_next        = DONE;
               w_timeout_evt = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end
         ANSWER: begin
            // A verdict on the last cycle of the window still counts.
            if (judge_wrong) begin
               w_next = DONE;
            end else if (judge_correct) begin
               w_next      = DONE;
               w_score_inc = 1'b1;
            end else if (w_tmr_zero) begin
               w_next        = DONE;
               w_timeout_evt = 1'b1;
            end else begin
               w_dec = 1'b1;
            end
         end
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_control    <= 1'b0;
         r_owner      <= OWN_NONE;
         r_round_done <= 1'b0;
         r_timed_out  <= 1'b0;
      end else begin
         r_control    <= (w_next == ARMED) || (w_next == ANSWER);
         r_round_done <= (w_next == DONE);
         if (w_start_ok) begin
            r_owner     <= OWN_NONE;
            r_timed_out <= 1'b0;
         end
         if (r_state == ARMED) begin
            if (led1 && led2)  r_owner <= OWN_TIE;
            else if (led1)     r_owner <= OWN_P1;
            else if (led2)     r_owner <= OWN_P2;
         end
         if (w_timeout_evt) r_timed_out <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_score1 <= '0;
         r_score2 <= '0;
      end else if ((r_state == IDLE) && clear_scores) begin
         r_score1 <= '0;
         r_score2 <= '0;
      end else if (w_score_inc) begin
         if ((r_owner == OWN_P1) && (r_score1 != c_score_max)) r_score1 <= r_score1 + 1'b1;
         if ((r_owner == OWN_P2) && (r_score2 != c_score_max)) r_score2 <= r_score2 + 1'b1;
      end
   end

   assign control    = r_control;
   assign owner      = r_owner;
   assign score1     = r_score1;
   assign score2     = r_score2;
   assign round_done = r_round_done;
   assign timed_out  = r_timed_out;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_round_host.sv
`default_nettype none
// ============================================================================
// tb_buzzer_round_host : directed vector table plus multi-cycle corner sequences
// Revision             : 1.0
// ============================================================================
module tb_buzzer_round_host;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_round = 1'b0;
   logic       clear_scores = 1'b0;
   logic       led1 = 1'b0;
   logic       led2 = 1'b0;
   logic       judge_correct = 1'b0;
   logic       judge_wrong = 1'b0;
   logic       control;
   logic [1:0] owner;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       round_done;
   logic       timed_out;

   int total = 0;
   int bad   = 0;
   int exp_s1 = 0;
   int exp_s2 = 0;

   buzzer_round_host #(.ARM_CYCLES(64), .ANSWER_CYCLES(16), .SCORE_W(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_round   (start_round),
      .clear_scores  (clear_scores),
      .led1          (led1),
      .led2          (led2),
      .judge_correct (judge_correct),
      .judge_wrong   (judge_wrong),
      .control       (control),
      .owner         (owner),
      .score1        (score1),
      .score2        (score2),
      .round_done    (round_done),
      .timed_out     (timed_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0]  in;    // {start, clear, led1, led2, correct, wrong}
      logic [12:0] exp;   // {control, owner, score1, score2, round_done, timed_out}
   } vec_t;

   vec_t vecs [24];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [5:0] in);
      {start_round, clear_scores, led1, led2, judge_correct, judge_wrong} = in;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic [5:0] in, input logic c, input logic [1:0] o,
                               input logic [3:0] s1, input logic [3:0] s2,
                               input logic d, input logic t);
      vec_t v;
      v.in  = in;
      v.exp = {c, o, s1, s2, d, t};
      return v;
   endfunction

   // One complete round: start, buzz, verdict, back to IDLE.
   task automatic do_round(input logic p2, input logic correct);
      drive(6'b100000); tick();
      drive(p2 ? 6'b000100 : 6'b001000); tick();
      drive(correct ? 6'b000010 : 6'b000001); tick();
      drive(6'b000000); tick();
      if (correct && !p2 && exp_s1 < 15) exp_s1++;
      if (correct &&  p2 && exp_s2 < 15) exp_s2++;
   endtask

   initial begin
      int n;
      vecs[0]  = mk(6'b100000, 1, 2'd0, 0, 0, 0, 0);
      vecs[1]  = mk(6'b000000, 1, 2'd0, 0, 0, 0, 0);
      vecs[2]  = mk(6'b001000, 1, 2'd1, 0, 0, 0, 0);
      vecs[3]  = mk(6'b000000, 1, 2'd1, 0, 0, 0, 0);
      vecs[4]  = mk(6'b000010, 0, 2'd1, 1, 0, 1, 0);
      vecs[5]  = mk(6'b000000, 0, 2'd1, 1, 0, 0, 0);
      vecs[6]  = mk(6'b100000, 1, 2'd0, 1, 0, 0, 0);
      vecs[7]  = mk(6'b001100, 0, 2'd3, 1, 0, 1, 0);
      vecs[8]  = mk(6'b000000, 0, 2'd3, 1, 0, 0, 0);
      vecs[9]  = mk(6'b100000, 1, 2'd0, 1, 0, 0, 0);
      vecs[10] = mk(6'b000100, 1, 2'd2, 1, 0, 0, 0);
      vecs[11] = mk(6'b000011, 0, 2'd2, 1, 0, 1, 0);
      vecs[12] = mk(6'b000000, 0, 2'd2, 1, 0, 0, 0);
      vecs[13] = mk(6'b110000, 1, 2'd0, 0, 0, 0, 0);
      vecs[14] = mk(6'b101000, 1, 2'd1, 0, 0, 0, 0);
      vecs[15] = mk(6'b000001, 0, 2'd1, 0, 0, 1, 0);
      vecs[16] = mk(6'b000000, 0, 2'd1, 0, 0, 0, 0);
      vecs[17] = mk(6'b001000, 0, 2'd1, 0, 0, 0, 0);
      vecs[18] = mk(6'b000010, 0, 2'd1, 0, 0, 0, 0);
      vecs[19] = mk(6'b100000, 1, 2'd0, 0, 0, 0, 0);
      vecs[20] = mk(6'b000010, 1, 2'd0, 0, 0, 0, 0);
      vecs[21] = mk(6'b001000, 1, 2'd1, 0, 0, 0, 0);
      vecs[22] = mk(6'b000010, 0, 2'd1, 1, 0, 1, 0);
      vecs[23] = mk(6'b000000, 0, 2'd1, 1, 0, 0, 0);

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", {19'd0, control, owner, score1, score2, round_done, timed_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #6;

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].in);
         tick();
         check($sformatf("vec%0d", i),
               {19'd0, control, owner, score1, score2, round_done, timed_out},
               {19'd0, vecs[i].exp});
      end
      exp_s1 = 1;
      exp_s2 = 0;

      // Buzz-window timeout; a start pulse mid-window must not restart the timer
      drive(6'b100000); tick();
      n = 0;
      for (int k = 0; k < 200; k++) begin
         drive((n == 10) ? 6'b100000 : 6'b000000);
         tick();
         n++;
         if (round_done) break;
      end
      drive(6'b000000);
      check("arm_window_len", n, 64);
      check("arm_timed_out", timed_out, 1);
      check("arm_owner_none", owner, 0);
      check("arm_scores", {score1, score2}, {exp_s1[3:0], exp_s2[3:0]});
      check("arm_control_off", control, 0);
      tick();
      check("done_one_cycle", round_done, 0);
      check("timed_out_held", timed_out, 1);
      drive(6'b100000); tick();
      check("start_clears_to", timed_out, 0);

      // Answer-window timeout
      drive(6'b000100); tick();
      check("p2_owner", owner, 2);
      drive(6'b000000);
      n = 0;
      for (int k = 0; k < 100; k++) begin
         tick();
         n++;
         if (round_done) break;
      end
      check("ans_window_len", n, 16);
      check("ans_timed_out", timed_out, 1);
      check("ans_scores", {score1, score2}, {exp_s1[3:0], exp_s2[3:0]});
      tick();

      // Verdict on the final cycle of the answer window is honoured
      drive(6'b100000); tick();
      drive(6'b000100); tick();
      drive(6'b000000);
      repeat (15) tick();
      check("ans_still_open", control, 1);
      drive(6'b000010); tick();
      exp_s2++;
      check("late_verdict_done", round_done, 1);
      check("late_verdict_s2", score2, exp_s2);
      check("late_verdict_to", timed_out, 0);
      drive(6'b000000); tick();

      // Saturation at 15
      for (int k = 0; k < 20 && exp_s1 < 15; k++) do_round(1'b0, 1'b1);
      check("s1_at_max", score1, 15);
      do_round(1'b0, 1'b1);
      check("s1_saturated", score1, 15);
      check("s2_untouched", score2, exp_s2);
      drive(6'b010000); tick();
      drive(6'b000000);
      exp_s1 = 0;
      exp_s2 = 0;
      check("clear_scores", {score1, score2}, 8'd0);

      // Asynchronous reset in the middle of ANSWER
      do_round(1'b0, 1'b1);
      check("pre_reset_s1", score1, 1);
      drive(6'b100000); tick();
      drive(6'b001000); tick();
      drive(6'b000000);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_outputs", {19'd0, control, owner, score1, score2, round_done, timed_out}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_idle", control, 0);
      drive(6'b100000); tick();
      drive(6'b000000);
      check("post_rst_start", control, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
